// File: rtl/rgb_fade_pkg.sv
// Shared constants and types for the RGB PWM fader: channel indices,
// per-channel ramp state and default timing parameters.
package rgb_fade_pkg;

  localparam int CH_R   = 0;
  localparam int CH_G   = 1;
  localparam int CH_B   = 2;
  localparam int NUM_CH = 3;

  localparam int DEF_PWM_BITS         = 8;
  localparam int DEF_FADE_STEP_CYCLES = 78_125;

  typedef enum logic [1:0] {
    ST_OFF,
    ST_RISING,
    ST_ON,
    ST_FALLING
  } ch_state_e;

endpackage

// File: rtl/rgb_pwm_fader_if.sv
// Sequencer-side levels and LED pad drives of the RGB PWM fader.
interface rgb_pwm_fader_if;

  logic led_r_in;
  logic led_g_in;
  logic led_b_in;
  logic enable;
  logic pwm_r;
  logic pwm_g;
  logic pwm_b;
  logic fade_busy;

  modport master (
    output led_r_in, led_g_in, led_b_in, enable,
    input  pwm_r, pwm_g, pwm_b, fade_busy
  );

  modport slave (
    input  led_r_in, led_g_in, led_b_in, enable,
    output pwm_r, pwm_g, pwm_b, fade_busy
  );

endinterface

// File: rtl/fade_channel.sv
// One colour channel: registered request, duty ramp toward 0 or MAX_DUTY,
// PWM compare against the shared counter and a registered pad driver.
//   state      | meaning
//   ST_OFF     | duty == 0 and target == 0
//   ST_RISING  | duty < target, +1 per enabled fade step
//   ST_ON      | duty == target == MAX_DUTY
//   ST_FALLING | duty > target, -1 per enabled fade step
module fade_channel
  import rgb_fade_pkg::*;
#(
  parameter int PWM_BITS   = DEF_PWM_BITS,
  parameter int MAX_DUTY   = (1 << PWM_BITS) - 1,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                led_in,
  input  logic                enable,
  input  logic                step,
  input  logic [PWM_BITS-1:0] pwm_cnt,
  output logic                pad,
  output logic                busy
);

  localparam logic [PWM_BITS-1:0] TOP_DUTY = PWM_BITS'(MAX_DUTY);

  logic                in_q;
  logic [PWM_BITS-1:0] duty;
  logic [PWM_BITS-1:0] duty_nxt;
  logic [PWM_BITS-1:0] target;
  ch_state_e           state;
  logic                lit;

  assign target = in_q ? TOP_DUTY : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_q <= 1'b0;
      duty <= '0;
      pad  <= ACTIVE_LOW;
    end else begin
      if (enable) begin
        in_q <= led_in;
      end
      duty <= duty_nxt;
      pad  <= (enable & lit) ^ ACTIVE_LOW;
    end
  end

  // Reversal needs no extra handling: the direction is re-derived from the
  // current duty every cycle, so a flipped target just turns the ramp around.
  always_comb begin
    if (duty < target) begin
      state = ST_RISING;
    end else if (duty > target) begin
      state = ST_FALLING;
    end else if (duty == '0) begin
      state = ST_OFF;
    end else begin
      state = ST_ON;
    end

    duty_nxt = duty;
    if (step && enable) begin
      case (state)
        ST_RISING:  duty_nxt = duty + PWM_BITS'(1);
        ST_FALLING: duty_nxt = duty - PWM_BITS'(1);
        default:    duty_nxt = duty;
      endcase
    end
  end

  always_comb begin
    lit  = duty > pwm_cnt;
    busy = (state == ST_RISING) || (state == ST_FALLING);
  end

endmodule

// File: rtl/rgb_pwm_fader.sv
// RGB LED cross-fader: shared PWM counter and fade-step prescaler feeding
// three independent fade channels, plus the registered fade_busy flag.
module rgb_pwm_fader
  import rgb_fade_pkg::*;
#(
  parameter int PWM_BITS         = DEF_PWM_BITS,
  parameter int FADE_STEP_CYCLES = DEF_FADE_STEP_CYCLES,
  parameter int MAX_DUTY         = (1 << PWM_BITS) - 1,
  parameter bit ACTIVE_LOW       = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  rgb_pwm_fader_if.slave  bus
);

  localparam int PRE_W = (FADE_STEP_CYCLES > 1) ? $clog2(FADE_STEP_CYCLES) : 1;
  // Period is 2^PWM_BITS-1 so that full-scale duty is lit every cycle.
  localparam logic [PWM_BITS-1:0] CNT_LAST = PWM_BITS'((1 << PWM_BITS) - 2);
  localparam logic [PRE_W-1:0]    PRE_LAST = PRE_W'(FADE_STEP_CYCLES - 1);

  logic [PWM_BITS-1:0] pwm_cnt;
  logic [PRE_W-1:0]    prescaler;
  logic                step;
  logic [NUM_CH-1:0]   led_in;
  logic [NUM_CH-1:0]   pad;
  logic [NUM_CH-1:0]   busy;
  logic                fade_busy_q;

  assign step = (prescaler == PRE_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pwm_cnt     <= '0;
      prescaler   <= '0;
      fade_busy_q <= 1'b0;
    end else begin
      pwm_cnt     <= (pwm_cnt == CNT_LAST) ? '0 : pwm_cnt + PWM_BITS'(1);
      prescaler   <= step ? '0 : prescaler + PRE_W'(1);
      fade_busy_q <= |busy;
    end
  end

  assign led_in[CH_R] = bus.led_r_in;
  assign led_in[CH_G] = bus.led_g_in;
  assign led_in[CH_B] = bus.led_b_in;

  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
    fade_channel #(
      .PWM_BITS   (PWM_BITS),
      .MAX_DUTY   (MAX_DUTY),
      .ACTIVE_LOW (ACTIVE_LOW)
    ) u_ch (
      .clk     (clk),
      .rst     (rst),
      .led_in  (led_in[ch]),
      .enable  (bus.enable),
      .step    (step),
      .pwm_cnt (pwm_cnt),
      .pad     (pad[ch]),
      .busy    (busy[ch])
    );
  end

  assign bus.pwm_r     = pad[CH_R];
  assign bus.pwm_g     = pad[CH_G];
  assign bus.pwm_b     = pad[CH_B];
  assign bus.fade_busy = fade_busy_q;

endmodule

// File: tb/tb_rgb_pwm_fader.sv
// Bench for rgb_pwm_fader: three instances (MAX_DUTY 15/10/5) share stimulus
// and are checked every cycle against an arithmetic model of the fade rules.
module tb_rgb_pwm_fader;

  localparam int PERIOD = 15;
  localparam int FSC    = 4;
  localparam int MD [3] = '{15, 10, 5};

  logic       clk;
  logic       rst;
  logic [2:0] lin;
  logic       en;
  bit         chk_on;

  int n_cmp;
  int n_bad;

  rgb_pwm_fader_if if0 ();
  rgb_pwm_fader_if if1 ();
  rgb_pwm_fader_if if2 ();

  assign if0.led_r_in = lin[0];
  assign if0.led_g_in = lin[1];
  assign if0.led_b_in = lin[2];
  assign if0.enable   = en;
  assign if1.led_r_in = lin[0];
  assign if1.led_g_in = lin[1];
  assign if1.led_b_in = lin[2];
  assign if1.enable   = en;
  assign if2.led_r_in = lin[0];
  assign if2.led_g_in = lin[1];
  assign if2.led_b_in = lin[2];
  assign if2.enable   = en;

  rgb_pwm_fader #(.PWM_BITS(4), .FADE_STEP_CYCLES(FSC), .MAX_DUTY(15), .ACTIVE_LOW(1'b1))
    dut0 (.clk(clk), .rst(rst), .bus(if0));
  rgb_pwm_fader #(.PWM_BITS(4), .FADE_STEP_CYCLES(FSC), .MAX_DUTY(10), .ACTIVE_LOW(1'b1))
    dut1 (.clk(clk), .rst(rst), .bus(if1));
  rgb_pwm_fader #(.PWM_BITS(4), .FADE_STEP_CYCLES(FSC), .MAX_DUTY(5), .ACTIVE_LOW(1'b1))
    dut2 (.clk(clk), .rst(rst), .bus(if2));

  logic act_pad [3][3];
  logic act_busy [3];

  assign act_pad[0][0] = if0.pwm_r;
  assign act_pad[0][1] = if0.pwm_g;
  assign act_pad[0][2] = if0.pwm_b;
  assign act_pad[1][0] = if1.pwm_r;
  assign act_pad[1][1] = if1.pwm_g;
  assign act_pad[1][2] = if1.pwm_b;
  assign act_pad[2][0] = if2.pwm_r;
  assign act_pad[2][1] = if2.pwm_g;
  assign act_pad[2][2] = if2.pwm_b;
  assign act_busy[0]   = if0.fade_busy;
  assign act_busy[1]   = if1.fade_busy;
  assign act_busy[2]   = if2.fade_busy;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: cyc counts edges since reset, so the PWM phase is cyc mod 15 and
  // a fade step falls on every edge where cyc mod 4 == 3.
  int cyc;
  int m_duty [3][3];
  bit m_inq [3][3];
  bit e_pad [3][3];
  bit e_busy [3];

  function automatic int tgt(int i, int c);
    return m_inq[i][c] ? MD[i] : 0;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      cyc <= 0;
      for (int i = 0; i < 3; i++) begin
        e_busy[i] <= 1'b0;
        for (int c = 0; c < 3; c++) begin
          m_duty[i][c] <= 0;
          m_inq[i][c]  <= 1'b0;
          e_pad[i][c]  <= 1'b1;
        end
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        e_busy[i] <= (m_duty[i][0] != tgt(i, 0)) || (m_duty[i][1] != tgt(i, 1)) ||
                     (m_duty[i][2] != tgt(i, 2));
        for (int c = 0; c < 3; c++) begin
          e_pad[i][c] <= !(en && (m_duty[i][c] > (cyc % PERIOD)));
          if (en && (cyc % FSC == FSC - 1))
            m_duty[i][c] <= m_duty[i][c] + ((m_duty[i][c] < tgt(i, c)) ? 1 : 0)
                                         - ((m_duty[i][c] > tgt(i, c)) ? 1 : 0);
          if (en) m_inq[i][c] <= lin[c];
        end
      end
      cyc <= cyc + 1;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      for (int i = 0; i < 3; i++) begin
        chk($sformatf("busy_dut%0d", i), {31'd0, act_busy[i]}, {31'd0, e_busy[i]});
        for (int c = 0; c < 3; c++)
          chk($sformatf("pad_dut%0d_ch%0d", i, c), {31'd0, act_pad[i][c]},
              {31'd0, e_pad[i][c]});
      end
    end
  end

  task automatic count_low(input int i, input int c, input int n, output int lows);
    lows = 0;
    repeat (n) begin
      @(negedge clk);
      if (act_pad[i][c] === 1'b0) lows++;
    end
  endtask

  int lows;
  int busy_len;
  int guard;

  initial begin
    n_cmp  = 0;
    n_bad  = 0;
    chk_on = 1'b0;
    rst    = 1'b1;
    lin    = 3'b000;
    en     = 1'b1;
    repeat (3) @(negedge clk);
    chk_on = 1'b1;
    chk("reset_pwm_r", {31'd0, if0.pwm_r}, 32'd1);
    chk("reset_busy", {31'd0, if0.fade_busy}, 32'd0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // red ramp to full scale
    lin[0] = 1'b1;
    @(negedge clk);
    chk("t2_busy_edge1", {31'd0, if0.fade_busy}, 32'd0);
    @(negedge clk);
    chk("t2_busy_edge2", {31'd0, if0.fade_busy}, 32'd1);
    repeat (70) @(negedge clk);
    count_low(0, 0, 15, lows);
    chk("t2_red_full_lows", lows, 15);
    chk("t2_busy_done", {31'd0, if0.fade_busy}, 32'd0);
    count_low(0, 1, 15, lows);
    chk("t2_green_lows", lows, 0);
    count_low(0, 2, 15, lows);
    chk("t2_blue_lows", lows, 0);

    // asynchronous reset mid-run, no clock edge in between
    #2 rst = 1'b1;
    lin = 3'b000;
    #1;
    chk("t1_async_pwm_r", {31'd0, if0.pwm_r}, 32'd1);
    chk("t1_async_pwm_g", {31'd0, if0.pwm_g}, 32'd1);
    chk("t1_async_pwm_b", {31'd0, if0.pwm_b}, 32'd1);
    chk("t1_async_busy", {31'd0, if0.fade_busy}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      count_low(0, c, 20, lows);
      chk($sformatf("t1_idle_lows_ch%0d", c), lows, 0);
    end

    // duty 5 (dut2 saturates at 5), freeze with enable low, resume
    lin[0] = 1'b1;
    repeat (30) @(negedge clk);
    count_low(2, 0, 45, lows);
    chk("t3_duty5_lows", lows, 15);
    en = 1'b0;
    count_low(0, 0, 15, lows);
    chk("t3_disabled_lows_dut0", lows, 0);
    count_low(2, 0, 15, lows);
    chk("t3_disabled_lows_dut2", lows, 0);
    en = 1'b1;
    count_low(2, 0, 45, lows);
    chk("t3_resumed_lows", lows, 15);

    // reversal at duty 8
    lin[0] = 1'b0;
    repeat (80) @(negedge clk);
    lin[0] = 1'b1;
    guard = 0;
    while (m_duty[0][0] != 8 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    chk("t4_model_reached8", m_duty[0][0], 8);
    lin[0] = 1'b0;
    busy_len = 0;
    guard = 0;
    while (guard < 100) begin
      @(negedge clk);
      guard++;
      if (if0.fade_busy === 1'b1) busy_len++;
      else break;
    end
    chk("t4_busy_len", busy_len, 32);
    chk("t4_model_at0", m_duty[0][0], 0);

    // green saturation at MAX_DUTY=10 (dut1)
    lin[1] = 1'b1;
    repeat (80) @(negedge clk);
    count_low(1, 1, 45, lows);
    chk("t5_duty10_lows", lows, 30);
    chk("t5_busy_dut1", {31'd0, if1.fade_busy}, 32'd0);

    // cross-fade red->green in lockstep
    lin = 3'b001;
    repeat (80) @(negedge clk);
    lin = 3'b010;
    repeat (70) begin
      @(negedge clk);
      chk("t6_model_sum", m_duty[0][0] + m_duty[0][1], 15);
    end
    chk("t6_busy_done", {31'd0, if0.fade_busy}, 32'd0);
    count_low(0, 0, 15, lows);
    chk("t6_red_lows", lows, 0);
    count_low(0, 1, 15, lows);
    chk("t6_green_lows", lows, 15);

    chk_on = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
